// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//
// Register file with a per-register pending scoreboard. Holds the general
// purpose registers, the PC and the CPSR. Decode/issue marks destination
// registers pending, and execute reads three ports together with busy flags.
// A writeback stores data and clears the pending mark. All state changes
// happen on the rising clock edge. Reads are combinational from registered
// state.
//
// Optional feature macro: RF_BYPASS_EN
//   When defined, a read of the register being written back returns the
//   writeback data and busy=0 in the same cycle. exe_cpsr_out also returns
//   the merged value while a CPSR write is in progress. Issue logic does not
//   change. When undefined, reads see registered state only.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   if_pc_we/in/out     - PC load enable, next PC, current PC
//   exe_{rd,rs,rt}_num  - read-port register selects
//   exe_*_data_out      - read data
//   exe_*_busy          - selected register is pending
//   exe_cpsr_out        - current CPSR
//   iss_valid/num/ready - issue request, destination, accepted this cycle
//   wb_rd_write_en/num/in   - register writeback
//   wb_cpsr_write_en/mask/in - masked CPSR write
//   pending_cnt         - number of pending registers (registered)
//   wb_err              - sticky: a writeback hit a non-pending register
// ----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int              DATA_W    = 32,
    parameter int              NUM_REGS  = 16,
    parameter int              AW        = 4,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int              ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_pc_we,
    input  logic [DATA_W-1:0] if_pc_in,
    output logic [DATA_W-1:0] if_pc_out,
    input  logic [AW-1:0]     exe_rd_num,
    input  logic [AW-1:0]     exe_rs_num,
    input  logic [AW-1:0]     exe_rt_num,
    output logic [DATA_W-1:0] exe_rd_data_out,
    output logic [DATA_W-1:0] exe_rs_data_out,
    output logic [DATA_W-1:0] exe_rt_data_out,
    output logic              exe_rd_busy,
    output logic              exe_rs_busy,
    output logic              exe_rt_busy,
    output logic [DATA_W-1:0] exe_cpsr_out,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_num,
    output logic              iss_ready,
    input  logic              wb_rd_write_en,
    input  logic [AW-1:0]     wb_rd_num,
    input  logic [DATA_W-1:0] wb_rd_in,
    input  logic              wb_cpsr_write_en,
    input  logic [DATA_W-1:0] wb_cpsr_mask,
    input  logic [DATA_W-1:0] wb_cpsr_in,
    output logic [AW:0]       pending_cnt,
    output logic              wb_err
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] cpsr_q, cpsr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              wbErr_q, wbErr_d;

    logic              wbHit;
    logic              issHit;
    logic [DATA_W-1:0] cpsrMerged;
    logic [AW-1:0]     rdNum  [3];
    logic [DATA_W-1:0] rdData [3];
    logic              rdBusy [3];

    // A register number is a real storage target only when it is in range
    // and is not the hard-wired zero register.
    function automatic logic isTarget(input logic [AW-1:0] num);
        isTarget = (32'(num) < 32'(NUM_REGS)) && !((ZERO_REG0 != 0) && (num == '0));
    endfunction

    assign wbHit      = wb_rd_write_en && isTarget(wb_rd_num);
    assign cpsrMerged = (cpsr_q & ~wb_cpsr_mask) | (wb_cpsr_in & wb_cpsr_mask);

    // A pending destination may be issued again if its writeback lands in
    // the same cycle. Non-targets always report ready, but the issue does nothing.
    always_comb begin
        iss_ready = 1'b1;
        if (isTarget(iss_num)) begin
            iss_ready = !pend_q[iss_num] || (wb_rd_write_en && (wb_rd_num == iss_num));
        end
    end

    assign issHit = iss_valid && iss_ready && isTarget(iss_num);

    assign rdNum[0] = exe_rd_num;
    assign rdNum[1] = exe_rs_num;
    assign rdNum[2] = exe_rt_num;

    // Read ports. Non-targets read as zero and are never busy. The bypass
    // forwards writeback data to a port that names the register being written.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (isTarget(rdNum[p])) begin
                rdData[p] = regs_q[rdNum[p]];
                rdBusy[p] = pend_q[rdNum[p]];
            end
`ifdef RF_BYPASS_EN
            if (wbHit && (rdNum[p] == wb_rd_num)) begin
                rdData[p] = wb_rd_in;
                rdBusy[p] = 1'b0;
            end
`endif
        end
    end

    assign exe_rd_data_out = rdData[0];
    assign exe_rs_data_out = rdData[1];
    assign exe_rt_data_out = rdData[2];
    assign exe_rd_busy     = rdBusy[0];
    assign exe_rs_busy     = rdBusy[1];
    assign exe_rt_busy     = rdBusy[2];

`ifdef RF_BYPASS_EN
    assign exe_cpsr_out = wb_cpsr_write_en ? cpsrMerged : cpsr_q;
`else
    assign exe_cpsr_out = cpsr_q;
`endif

    assign if_pc_out   = pc_q;
    assign pending_cnt = cnt_q;
    assign wb_err      = wbErr_q;

    // Next-state logic. The issue mark is applied after the writeback clear,
    // so a same-cycle issue and writeback to one register leaves it pending.
    // The count is taken from the next pending vector so the registered
    // count always matches the registered vector.
    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        pc_d    = if_pc_we ? if_pc_in : pc_q;
        cpsr_d  = wb_cpsr_write_en ? cpsrMerged : cpsr_q;
        wbErr_d = wbErr_q;
        if (wbHit) begin
            regs_d[wb_rd_num] = wb_rd_in;
            pend_d[wb_rd_num] = 1'b0;
            if (!pend_q[wb_rd_num]) begin
                wbErr_d = 1'b1;
            end
        end
        if (issHit) begin
            pend_d[iss_num] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    // State registers. Reset takes priority over every other update in the
    // same cycle and drops all in-flight pending marks.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            pend_q  <= '0;
            pc_q    <= PC_RESET;
            cpsr_q  <= '0;
            cnt_q   <= '0;
            wbErr_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            cpsr_q  <= cpsr_d;
            cnt_q   <= cnt_d;
            wbErr_q <= wbErr_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Self-checking bench for reg_file_sb. It is built with PC_RESET=0x100 and
// ZERO_REG0=1. Each scenario task drives stimulus and pushes the values it
// expects onto a queue. It then pops them and compares them against the
// DUT outputs.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_pc_we;
    logic [31:0] if_pc_in, if_pc_out;
    logic [3:0]  exe_rd_num, exe_rs_num, exe_rt_num;
    logic [31:0] exe_rd_data_out, exe_rs_data_out, exe_rt_data_out;
    logic        exe_rd_busy, exe_rs_busy, exe_rt_busy;
    logic [31:0] exe_cpsr_out;
    logic        iss_valid;
    logic [3:0]  iss_num;
    logic        iss_ready;
    logic        wb_rd_write_en;
    logic [3:0]  wb_rd_num;
    logic [31:0] wb_rd_in;
    logic        wb_cpsr_write_en;
    logic [31:0] wb_cpsr_mask, wb_cpsr_in;
    logic [4:0]  pending_cnt;
    logic        wb_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] expQ[$];

    reg_file_sb #(
        .DATA_W(32), .NUM_REGS(16), .AW(4),
        .PC_RESET(32'h0000_0100), .ZERO_REG0(1)
    ) dut (
        .clk(clk), .reset(reset),
        .if_pc_we(if_pc_we), .if_pc_in(if_pc_in), .if_pc_out(if_pc_out),
        .exe_rd_num(exe_rd_num), .exe_rs_num(exe_rs_num), .exe_rt_num(exe_rt_num),
        .exe_rd_data_out(exe_rd_data_out), .exe_rs_data_out(exe_rs_data_out),
        .exe_rt_data_out(exe_rt_data_out),
        .exe_rd_busy(exe_rd_busy), .exe_rs_busy(exe_rs_busy), .exe_rt_busy(exe_rt_busy),
        .exe_cpsr_out(exe_cpsr_out),
        .iss_valid(iss_valid), .iss_num(iss_num), .iss_ready(iss_ready),
        .wb_rd_write_en(wb_rd_write_en), .wb_rd_num(wb_rd_num), .wb_rd_in(wb_rd_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_mask(wb_cpsr_mask),
        .wb_cpsr_in(wb_cpsr_in),
        .pending_cnt(pending_cnt), .wb_err(wb_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        reset = 1'b0; if_pc_we = 1'b0; if_pc_in = '0;
        exe_rd_num = '0; exe_rs_num = '0; exe_rt_num = '0;
        iss_valid = 1'b0; iss_num = '0;
        wb_rd_write_en = 1'b0; wb_rd_num = '0; wb_rd_in = '0;
        wb_cpsr_write_en = 1'b0; wb_cpsr_mask = '0; wb_cpsr_in = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iss_num = 4'd3;
        #1;
        expQ.push_back(32'h100); expQ.push_back(32'd0); expQ.push_back(32'd0);
        expQ.push_back(32'd1);   expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (if_pc_out !== exp) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=%h", if_pc_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=%0d", pending_cnt, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL reset_wberr got=%0d exp=%0d", wb_err, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(iss_ready) !== exp) begin errors++; $display("[TB] FAIL reset_issready got=%0d exp=%0d", iss_ready, exp); end
        exp = expQ.pop_front(); checks++;
        if (exe_cpsr_out !== exp) begin errors++; $display("[TB] FAIL reset_cpsr got=%h exp=%h", exe_cpsr_out, exp); end
        for (int r = 0; r < 16; r++) begin
            exe_rs_num = 4'(r);
            expQ.push_back(32'd0);
            #1;
            exp = expQ.pop_front(); checks++;
            if (exe_rs_data_out !== exp || exe_rs_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d got=%h/%0d exp=%h/0", r, exe_rs_data_out, exe_rs_busy, exp);
            end
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] exp;
        clearInputs();
        iss_valid = 1'b1; iss_num = 4'd3;
        #1;
        expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(iss_ready) !== exp) begin errors++; $display("[TB] FAIL sb_ready1 got=%0d exp=%0d", iss_ready, exp); end
        tick();
        iss_valid = 1'b0; exe_rs_num = 4'd3;
        #1;
        expQ.push_back(32'd1); expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rs_busy) !== exp) begin errors++; $display("[TB] FAIL sb_busy got=%0d exp=%0d", exe_rs_busy, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL sb_cnt1 got=%0d exp=%0d", pending_cnt, exp); end
        iss_valid = 1'b1;
        #1;
        expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (32'(iss_ready) !== exp) begin errors++; $display("[TB] FAIL sb_ready2 got=%0d exp=%0d", iss_ready, exp); end
        tick();
        iss_valid = 1'b0;
        expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL sb_hold_cnt got=%0d exp=%0d", pending_cnt, exp); end
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd3; wb_rd_in = 32'hDEAD_BEEF;
        tick();
        wb_rd_write_en = 1'b0;
        #1;
        expQ.push_back(32'hDEAD_BEEF); expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (exe_rs_data_out !== exp) begin errors++; $display("[TB] FAIL sb_data got=%h exp=%h", exe_rs_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rs_busy) !== exp) begin errors++; $display("[TB] FAIL sb_busy_clr got=%0d exp=%0d", exe_rs_busy, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL sb_cnt0 got=%0d exp=%0d", pending_cnt, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL sb_wberr got=%0d exp=%0d", wb_err, exp); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp;
        clearInputs();
        iss_valid = 1'b1; iss_num = 4'd5;
        tick();
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd5; wb_rd_in = 32'h11;
        #1;
        expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(iss_ready) !== exp) begin errors++; $display("[TB] FAIL sim_ready got=%0d exp=%0d", iss_ready, exp); end
        tick();
        clearInputs();
        exe_rd_num = 4'd5;
        #1;
        expQ.push_back(32'h11); expQ.push_back(32'd1); expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (exe_rd_data_out !== exp) begin errors++; $display("[TB] FAIL sim_data got=%h exp=%h", exe_rd_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rd_busy) !== exp) begin errors++; $display("[TB] FAIL sim_busy got=%0d exp=%0d", exe_rd_busy, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL sim_cnt got=%0d exp=%0d", pending_cnt, exp); end
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd5; wb_rd_in = 32'h22;
        tick();
        wb_rd_write_en = 1'b0;
        expQ.push_back(32'd0); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL sim_cnt_clr got=%0d exp=%0d", pending_cnt, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL sim_wberr got=%0d exp=%0d", wb_err, exp); end
    endtask

    task automatic test_cpsr();
        logic [31:0] exp;
        clearInputs();
        wb_cpsr_write_en = 1'b1; wb_cpsr_mask = 32'hFFFF_FFFF; wb_cpsr_in = 32'hF000_000F;
        tick();
        wb_cpsr_mask = 32'hF000_0000; wb_cpsr_in = 32'h0;
        #1;
`ifdef RF_BYPASS_EN
        expQ.push_back(32'h0000_000F);
`else
        expQ.push_back(32'hF000_000F);
`endif
        exp = expQ.pop_front(); checks++;
        if (exe_cpsr_out !== exp) begin errors++; $display("[TB] FAIL cpsr_during got=%h exp=%h", exe_cpsr_out, exp); end
        tick();
        wb_cpsr_write_en = 1'b0;
        #1;
        expQ.push_back(32'h0000_000F);
        exp = expQ.pop_front(); checks++;
        if (exe_cpsr_out !== exp) begin errors++; $display("[TB] FAIL cpsr_masked got=%h exp=%h", exe_cpsr_out, exp); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        clearInputs();
        iss_valid = 1'b1; iss_num = 4'd2;
        tick();
        iss_valid = 1'b0;
        exe_rt_num = 4'd2;
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd2; wb_rd_in = 32'h55;
        #1;
`ifdef RF_BYPASS_EN
        expQ.push_back(32'h55); expQ.push_back(32'd0);
`else
        expQ.push_back(32'h0);  expQ.push_back(32'd1);
`endif
        exp = expQ.pop_front(); checks++;
        if (exe_rt_data_out !== exp) begin errors++; $display("[TB] FAIL byp_same_data got=%h exp=%h", exe_rt_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rt_busy) !== exp) begin errors++; $display("[TB] FAIL byp_same_busy got=%0d exp=%0d", exe_rt_busy, exp); end
        tick();
        wb_rd_write_en = 1'b0;
        #1;
        expQ.push_back(32'h55); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (exe_rt_data_out !== exp) begin errors++; $display("[TB] FAIL byp_next_data got=%h exp=%h", exe_rt_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rt_busy) !== exp) begin errors++; $display("[TB] FAIL byp_next_busy got=%0d exp=%0d", exe_rt_busy, exp); end
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp;
        clearInputs();
        exe_rd_num = 4'd0;
        iss_valid = 1'b1; iss_num = 4'd0;
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd0; wb_rd_in = 32'h9;
        #1;
        expQ.push_back(32'd1); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (32'(iss_ready) !== exp) begin errors++; $display("[TB] FAIL zero_ready got=%0d exp=%0d", iss_ready, exp); end
        exp = expQ.pop_front(); checks++;
        if (exe_rd_data_out !== exp) begin errors++; $display("[TB] FAIL zero_same got=%h exp=%h", exe_rd_data_out, exp); end
        tick();
        clearInputs();
        exe_rd_num = 4'd0;
        #1;
        expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (exe_rd_data_out !== exp) begin errors++; $display("[TB] FAIL zero_data got=%h exp=%h", exe_rd_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rd_busy) !== exp) begin errors++; $display("[TB] FAIL zero_busy got=%0d exp=%0d", exe_rd_busy, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL zero_wberr got=%0d exp=%0d", wb_err, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL zero_cnt got=%0d exp=%0d", pending_cnt, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int mCnt = 0;
        clearInputs();
        for (int r = 8; r <= 12; r++) begin
            iss_valid = 1'b1; iss_num = 4'(r);
            tick();
            mCnt++;
            expQ.push_back(32'(mCnt));
            exp = expQ.pop_front(); checks++;
            if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL b2b_iss_cnt r%0d got=%0d exp=%0d", r, pending_cnt, exp); end
        end
        iss_valid = 1'b0;
        for (int r = 8; r <= 12; r++) begin
            wb_rd_write_en = 1'b1; wb_rd_num = 4'(r); wb_rd_in = 32'(r) * 32'h0101;
            tick();
            mCnt--;
            expQ.push_back(32'(mCnt));
            exp = expQ.pop_front(); checks++;
            if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL b2b_wb_cnt r%0d got=%0d exp=%0d", r, pending_cnt, exp); end
        end
        wb_rd_write_en = 1'b0;
        for (int r = 8; r <= 12; r++) begin
            exe_rs_num = 4'(r);
            expQ.push_back(32'(r) * 32'h0101);
            #1;
            exp = expQ.pop_front(); checks++;
            if (exe_rs_data_out !== exp) begin errors++; $display("[TB] FAIL b2b_data r%0d got=%h exp=%h", r, exe_rs_data_out, exp); end
        end
    endtask

    task automatic test_error();
        logic [31:0] exp;
        clearInputs();
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd7; wb_rd_in = 32'h77;
        tick();
        wb_rd_write_en = 1'b0;
        expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL err_set got=%0d exp=%0d", wb_err, exp); end
        repeat (3) tick();
        expQ.push_back(32'd1);
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL err_sticky got=%0d exp=%0d", wb_err, exp); end
    endtask

    task automatic test_pc();
        logic [31:0] exp;
        clearInputs();
        if_pc_we = 1'b1; if_pc_in = 32'h2000;
        tick();
        if_pc_we = 1'b0; if_pc_in = 32'h3000;
        expQ.push_back(32'h2000);
        exp = expQ.pop_front(); checks++;
        if (if_pc_out !== exp) begin errors++; $display("[TB] FAIL pc_load got=%h exp=%h", if_pc_out, exp); end
        tick();
        expQ.push_back(32'h2000);
        exp = expQ.pop_front(); checks++;
        if (if_pc_out !== exp) begin errors++; $display("[TB] FAIL pc_hold got=%h exp=%h", if_pc_out, exp); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] exp;
        clearInputs();
        iss_valid = 1'b1; iss_num = 4'd6;
        tick();
        reset = 1'b1;
        iss_num = 4'd1;
        wb_rd_write_en = 1'b1; wb_rd_num = 4'd4; wb_rd_in = 32'hAA;
        if_pc_we = 1'b1; if_pc_in = 32'h5000;
        wb_cpsr_write_en = 1'b1; wb_cpsr_mask = 32'hFFFF_FFFF; wb_cpsr_in = 32'h1234;
        tick();
        clearInputs();
        exe_rd_num = 4'd4; exe_rs_num = 4'd6;
        #1;
        expQ.push_back(32'd0); expQ.push_back(32'd0); expQ.push_back(32'd0);
        expQ.push_back(32'h100); expQ.push_back(32'd0); expQ.push_back(32'd0);
        exp = expQ.pop_front(); checks++;
        if (32'(pending_cnt) !== exp) begin errors++; $display("[TB] FAIL mid_cnt got=%0d exp=%0d", pending_cnt, exp); end
        exp = expQ.pop_front(); checks++;
        if (exe_rd_data_out !== exp) begin errors++; $display("[TB] FAIL mid_r4 got=%h exp=%h", exe_rd_data_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(exe_rs_busy) !== exp) begin errors++; $display("[TB] FAIL mid_r6busy got=%0d exp=%0d", exe_rs_busy, exp); end
        exp = expQ.pop_front(); checks++;
        if (if_pc_out !== exp) begin errors++; $display("[TB] FAIL mid_pc got=%h exp=%h", if_pc_out, exp); end
        exp = expQ.pop_front(); checks++;
        if (32'(wb_err) !== exp) begin errors++; $display("[TB] FAIL mid_wberr got=%0d exp=%0d", wb_err, exp); end
        exp = expQ.pop_front(); checks++;
        if (exe_cpsr_out !== exp) begin errors++; $display("[TB] FAIL mid_cpsr got=%h exp=%h", exe_cpsr_out, exp); end
    endtask

    // Scenario sequence. The error test runs late because wb_err is sticky.
    initial begin
        clearInputs();
        test_reset();
        test_scoreboard();
        test_simultaneous();
        test_cpsr();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        test_pc();
        test_error();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised, clocked successor to the pipeline register file.
- Holds the general-purpose registers, PC and CPSR, and adds a per-register pending scoreboard so issue logic can detect RAW/WAW hazards.
- Sits between decode/issue (marks destinations pending), execute (three read ports plus busy flags) and writeback (data write clears pending).
- All state updates happen on the clock edge; reads are combinational from registered state.

Parameters:
- DATA_W, 32, register/PC/CPSR width.
- NUM_REGS, 16, number of general registers; must be ≥2.
- AW, 4, register-number width; NUM_REGS ≤ 2**AW.
- PC_RESET, 0, PC value loaded on reset.
- ZERO_REG0, 0, when 1 register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk in 1: single clock; all state updates on its rising edge.
- reset in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- if_pc_we in 1: PC load enable.
- if_pc_in in DATA_W: next PC value.
- if_pc_out out DATA_W: current PC.
- exe_rd_num / exe_rs_num / exe_rt_num in AW each: read-port selects.
- exe_rd_data_out / exe_rs_data_out / exe_rt_data_out out DATA_W each: read data.
- exe_rd_busy / exe_rs_busy / exe_rt_busy out 1 each: selected register is pending.
- exe_cpsr_out out DATA_W: current CPSR.
- iss_valid in 1: issue request marking iss_num pending.
- iss_num in AW: destination being issued.
- iss_ready out 1: issue accepted this cycle.
- wb_rd_write_en in 1: writeback enable.
- wb_rd_num in AW: writeback destination.
- wb_rd_in in DATA_W: writeback data.
- wb_cpsr_write_en in 1: CPSR write enable.
- wb_cpsr_mask in DATA_W: per-bit CPSR write mask.
- wb_cpsr_in in DATA_W: CPSR write data.
- pending_cnt out AW+1: number of pending registers.
- wb_err out 1: sticky; a writeback hit a register that was not pending.

Behaviour:
Reset:
- On a reset edge: all regs 0, PC=PC_RESET, CPSR=0, pending vector 0, wb_err 0, hence pending_cnt 0.
- Reset overrides any issue, writeback or PC load in the same cycle.
- Reset mid-operation discards all in-flight pending marks.

Reads:
- data_out = regs[num]; busy = pending[num].
- num ≥ NUM_REGS reads 0, busy 0.
- ZERO_REG0=1 and num=0: data 0, busy 0.

Writeback:
- On the edge with wb_rd_write_en=1 and wb_rd_num < NUM_REGS: regs[wb_rd_num] <= wb_rd_in and pending[wb_rd_num] <= 0.
- Visible on read ports from the next cycle (1-cycle write-to-read latency without the optional feature).
- Out-of-range or reg0-with-ZERO_REG0 writes are ignored.
- If the target was not pending (and the write is not ignored), wb_err <= 1; it stays 1 until reset.

Issue:
- iss_ready = !pending[iss_num] || (wb_rd_write_en && wb_rd_num==iss_num).
- Forced 1 for reg0 with ZERO_REG0 and for out-of-range iss_num (issue has no effect in both cases).
- iss_valid && iss_ready sets pending[iss_num] on the edge.
- Same-cycle accepted issue and writeback to the same register: data written and pending ends 1 (set wins).
- iss_valid with iss_ready=0: no state change; requester holds.

PC:
- if_pc_we=1 loads if_pc_in on the edge; otherwise PC holds.

CPSR:
- On wb_cpsr_write_en: cpsr <= (cpsr & ~mask) | (wb_cpsr_in & mask).

pending_cnt:
- Registered popcount of the pending vector; always consistent with the state after each edge; never exceeds NUM_REGS.

Optional Feature:
RF_BYPASS_EN
- Defined: any read port whose num equals wb_rd_num while wb_rd_write_en=1 (non-ignored target) returns wb_rd_in and busy=0 in the same cycle.
- Defined: exe_cpsr_out returns the masked-merged CPSR value during wb_cpsr_write_en.
- Defined: issue-side logic is unchanged.
- Not defined: reads return registered state only; same-cycle writes become visible the following cycle.

Test Plan:
- Reset: assert reset 1 cycle with PC_RESET=0x100 → if_pc_out=0x100, all data_out 0, pending_cnt 0, wb_err 0, iss_ready 1.
- Scoreboard: issue r3 → next cycle exe_rs_num=3 gives busy 1, pending_cnt 1. Second issue to r3 → iss_ready 0. wb r3=0xDEADBEEF → following cycle data 0xDEADBEEF, busy 0, pending_cnt 0.
- Simultaneous: r5 pending; same cycle wb r5=0x11 and issue r5 → iss_ready 1; next cycle r5 reads 0x11, busy 1, pending_cnt 1.
- Error and CPSR: wb r7 with r7 not pending → wb_err 1 and stays 1. CPSR=0xF000000F, write 0x0 with mask 0xF0000000 → CPSR=0x0000000F.
- Bypass: wb r2=0x55 with exe_rt_num=2 → with RF_BYPASS_EN, same-cycle rt data 0x55; without it, old value, then 0x55 next cycle.
- Reset mid-operation: issue r1 and wb r4 in the reset cycle → after the edge pending_cnt 0, r4 reads 0. ZERO_REG0=1: wb r0=0x9 → r0 reads 0, wb_err 0.
